// File: rtl/alu_scheduler.sv
// alu_scheduler: two-requester round-robin front end for a multi-cycle ALU.
// It accepts one request at a time, issues it to the ALU, and waits for the
// ALU END rising edge or a timeout. It then returns the result (or an error)
// and holds it until the consumer accepts it.
module alu_scheduler #(
    parameter int TIMEOUT = 200,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_x,
    input  logic [15:0] req_y,
    input  logic [15:0] req_adiv,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        alu_begin,
    output logic [1:0]  alu_op,
    output logic [7:0]  alu_x,
    output logic [7:0]  alu_y,
    output logic [7:0]  alu_adiv,
    output logic        alu_resetn,
    input  logic        alu_end,
    input  logic [15:0] alu_out,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_ABORT
    } state_t;

    state_t            state_q;
    logic              last_grant_q;
    logic              id_q;
    logic              end_prev_q;
    logic              rsp_err_q;
    logic [1:0]        op_q;
    logic [7:0]        x_q;
    logic [7:0]        y_q;
    logic [7:0]        adiv_q;
    logic [15:0]       rsp_data_q;
    logic [TO_W-1:0]   cnt_q;

    logic              grant_d;
    logic              accept_d;
    logic              done_d;
    logic [TO_W-1:0]   cnt_d;

    // Arbitration winner, END edge detect and next wait count.
    always_comb begin
        grant_d = 1'b0;
        if (req_valid == 2'b10) begin
            grant_d = 1'b1;
        end else if (req_valid == 2'b11) begin
            grant_d = ~last_grant_q;
        end
        done_d = alu_end & ~end_prev_q;
        cnt_d  = cnt_q + 1'b1;
    end

    // Grant is offered only while idle; gated by resetn so it drops during reset.
    assign req_ready  = (resetn && (state_q == S_IDLE) && (req_valid != 2'b00)) ?
                        (grant_d ? 2'b10 : 2'b01) : 2'b00;
    assign accept_d   = |(req_valid & req_ready);

    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_id     = id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign alu_begin  = (state_q == S_ISSUE);
    assign alu_op     = op_q;
    assign alu_x      = x_q;
    assign alu_y      = y_q;
    assign alu_adiv   = adiv_q;
    assign alu_resetn = resetn & (state_q != S_ABORT);
    assign busy       = (state_q != S_IDLE);

    // Scheduler FSM with holding registers and response capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            end_prev_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            op_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            adiv_q       <= '0;
            rsp_data_q   <= '0;
            cnt_q        <= '0;
        end else begin
            end_prev_q <= alu_end;
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        op_q         <= grant_d ? req_op[3:2]     : req_op[1:0];
                        x_q          <= grant_d ? req_x[15:8]     : req_x[7:0];
                        y_q          <= grant_d ? req_y[15:8]     : req_y[7:0];
                        adiv_q       <= grant_d ? req_adiv[15:8]  : req_adiv[7:0];
                        id_q         <= grant_d;
                        last_grant_q <= grant_d;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_d;
                    // A completion edge wins over a simultaneous timeout.
                    if (done_d) begin
                        rsp_data_q <= alu_out;
                        rsp_err_q  <= 1'b0;
                        state_q    <= S_RESP;
                    end else if (cnt_d == TO_W'(TIMEOUT)) begin
                        state_q <= S_ABORT;
                    end
                end
                S_ABORT: begin
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b1;
                    state_q    <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
